wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-end general-purpose register file for the 10-bit pipeline. It consumes the writeback fields emitted by the execute/memory-writeback pipeline register: write enable, 3-bit destination address and 10-bit load data. It provides eight 10-bit registers with two synchronous read ports and same-cycle write-to-read bypass. A load scoreboard flags registers with an outstanding load and stalls decode on a read-after-load hazard.

## Interface
Parameters:
- DATA_WIDTH, 10, register and data width
- ADDR_WIDTH, 3, register address width; register count NUM_REGS = 2**ADDR_WIDTH (8)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wb_en  in  1  writeback enable, from the pipeline register write-enable output
- wb_addr  in  ADDR_WIDTH  writeback destination register
- wb_data  in  DATA_WIDTH  writeback data (RAM read data)
- rd_en1, rd_en2  in  1 each  decode uses read port 1 / 2 this cycle
- rd_addr1, rd_addr2  in  ADDR_WIDTH each  read addresses
- rd_data1, rd_data2  out  DATA_WIDTH each  registered read data
- issue_load  in  1  decode issues a load this cycle
- issue_addr  in  ADDR_WIDTH  destination of the issued load
- stall  out  1  combinational read-after-load hazard flag
- pending  out  NUM_REGS  registered scoreboard; bit n set means a load to register n is outstanding

## Operation
- Reset (reset=1 at a rising edge):
  - all eight registers, rd_data1, rd_data2 and pending go to 0.
  - A wb_en or issue_load in the same cycle is ignored.
  - Reset mid-operation discards all outstanding loads.
- Write: at an edge with wb_en=1 and reset=0, regs[wb_addr] <= wb_data. All eight registers are writable; there is no hardwired zero.
- Read:
  - At every edge, rd_dataK <= regs[rd_addrK], independent of rd_enK.
  - Bypass: if wb_en=1 and wb_addr==rd_addrK in the same cycle, rd_dataK <= wb_data rather than the stale value.
  - Both ports may read the same address.
- Scoreboard, per register n at each edge:
  - set = issue_load & ~stall & issue_addr==n
  - clr = wb_en & wb_addr==n
  - pending[n] <= set | (pending[n] & ~clr)
  - When set and clr hit the same register in one cycle, set wins: a new load overtakes the completing one and the bit stays 1.
- Stall (combinational):
  - stall = OR over K of (rd_enK & pending[rd_addrK] & ~(wb_en & wb_addr==rd_addrK)).
  - A register being written back this cycle does not stall; the bypass delivers its data.
  - issue_load is ignored while stall=1, because decode holds the instruction.
- The load destination itself does not raise stall (no write-after-write check). A second load to an already pending register simply leaves the bit set.
- reset forces stall to 0 in its cycle.

## Timing
- Write latency: data written at edge T is visible from regs at edge T+1. Through the bypass it is captured into rd_data at edge T.
- Read latency: 1 cycle. The address presented in cycle T appears on rd_data after edge T.
- pending updates at the edge; stall reflects current-cycle inputs and pending with no register delay.
- Reset values: rd_data1=0, rd_data2=0, pending=0, stall=0.
- No handshake back-pressure on the write port: writeback always completes in one cycle.

## Test plan
- Reset, then write r5=0x2A5 (wb_en=1), then read rd_addr1=5 -> rd_data1=0x2A5 one cycle later; all other registers read 0.
- wb_en=1, wb_addr=3, wb_data=0x155 with rd_addr1=rd_addr2=3 in the same cycle -> both rd_data=0x155 after that edge (bypass), never the old value.
- issue_load to r2; next cycle rd_en1=1, rd_addr1=2 -> stall=1, pending=8'b0000_0100. Then wb_en to r2 with 0x3FF -> stall=0 that cycle, rd_data1=0x3FF, pending=0 after the edge.
- Same cycle: pending[4]=1, wb_en to r4 and issue_load to r4 (no stall) -> pending[4] stays 1. Same cycle with stall=1 from another port -> issue ignored, pending[4] clears.
- Loads outstanding on r1 and r7, registers nonzero, then assert reset for one cycle with wb_en=1 -> pending=0, rd_data=0, all registers 0, write ignored.
- Read r6 via port 2 with rd_en2=0 while pending[6]=1 -> stall=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-end register file: eight registers, two registered read ports with
// write-to-read bypass, and a load scoreboard that stalls decode on read-after-load.
module wb_regfile #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_en,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         rd_en1,
  input  logic [ADDR_WIDTH-1:0]        rd_addr1,
  input  logic                         rd_en2,
  input  logic [ADDR_WIDTH-1:0]        rd_addr2,
  output logic [DATA_WIDTH-1:0]        rd_data1,
  output logic [DATA_WIDTH-1:0]        rd_data2,
  input  logic                         issue_load,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  output logic                         stall,
  output logic [(2**ADDR_WIDTH)-1:0]   pending
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  logic byp1, byp2;
  logic hit1, hit2;
  logic stall_c;

  // A register completing its writeback this cycle never stalls: the bypass
  // hands its data straight to the read port.
  always_comb begin
    byp1       = wb_en && (wb_addr == rd_addr1);
    byp2       = wb_en && (wb_addr == rd_addr2);
    hit1       = rd_en1 && pending_q[rd_addr1] && !byp1;
    hit2       = rd_en2 && pending_q[rd_addr2] && !byp2;
    stall_c    = !reset && (hit1 || hit2);
    rd_data1_d = byp1 ? wb_data : regs_q[rd_addr1];
    rd_data2_d = byp2 ? wb_data : regs_q[rd_addr2];
  end

  // Set beats clear: a new load overtaking a completing one keeps the bit high.
  // A stalled decode holds its instruction, so its load is not issued yet.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    pending_d = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      pending_d[n] = (issue_load && !stall_c && (issue_addr == ADDR_WIDTH'(n)))
                  || (pending_q[n] && !(wb_en && (wb_addr == ADDR_WIDTH'(n))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is reset because software relies on every
      // register reading zero after reset; this forces flops rather than a RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      pending_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (wb_en) begin
        regs_q[wb_addr] <= wb_data;
      end
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      pending_q  <= pending_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign pending  = pending_q;
  assign stall    = stall_c;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed cycles push hand-computed expectations,
// a monitor pops them, checking stall mid-cycle and registered outputs after the edge.
module tb_wb_regfile;

  logic       clk;
  logic       reset;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [9:0] wb_data;
  logic       rd_en1, rd_en2;
  logic [2:0] rd_addr1, rd_addr2;
  logic [9:0] rd_data1, rd_data2;
  logic       issue_load;
  logic [2:0] issue_addr;
  logic       stall;
  logic [7:0] pending;

  wb_regfile #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rd_en1     (rd_en1),
    .rd_addr1   (rd_addr1),
    .rd_en2     (rd_en2),
    .rd_addr2   (rd_addr2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .issue_load (issue_load),
    .issue_addr (issue_addr),
    .stall      (stall),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       stall;
    logic [9:0] rd1;
    logic [9:0] rd2;
    logic [7:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;
  bit   busy     = 1'b0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // One cycle of stimulus plus the expected stall for this cycle and the
  // expected registered outputs after the following edge.
  task automatic step(input logic rst, input logic we, input logic [2:0] wa, input logic [9:0] wd,
                      input logic e1, input logic [2:0] a1, input logic e2, input logic [2:0] a2,
                      input logic il, input logic [2:0] ia,
                      input logic xs, input logic [9:0] x1, input logic [9:0] x2, input logic [7:0] xp);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; wb_en = we; wb_addr = wa; wb_data = wd;
    rd_en1 = e1; rd_addr1 = a1; rd_en2 = e2; rd_addr2 = a2;
    issue_load = il; issue_addr = ia;
    e.idx = n_step; e.stall = xs; e.rd1 = x1; e.rd2 = x2; e.pend = xp;
    exp_q.push_back(e);
    n_step++;
  endtask

  initial begin : monitor
    exp_t cur;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        busy = 1'b1;
        check("stall", cur.idx, 32'(stall), 32'(cur.stall));
        @(posedge clk);
        #2;
        check("rd_data1", cur.idx, 32'(rd_data1), 32'(cur.rd1));
        check("rd_data2", cur.idx, 32'(rd_data2), 32'(cur.rd2));
        check("pending",  cur.idx, 32'(pending),  32'(cur.pend));
        busy = 1'b0;
      end
    end
  end

  initial begin : driver
    reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rd_en1 = 1'b0; rd_addr1 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
    issue_load = 1'b0; issue_addr = '0;

    //    rst we wa    wd      e1 a1  e2 a2  il ia    stall rd1     rd2     pend
    // reset with a write and a load in the same cycle: both ignored
    step(1, 1, 3'd0, 10'h3FF, 0, 3'd0, 0, 3'd0, 1, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 1, 3'd5, 10'h2A5, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 0, 3'd5, 0, 3'd0, 0, 3'd0, 0, 10'h2A5, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 0, 3'd1, 0, 3'd2, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 0, 3'd3, 0, 3'd4, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 0, 3'd6, 0, 3'd7, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    // bypass on both ports, then bypass over a stale nonzero value
    step(0, 1, 3'd3, 10'h155, 0, 3'd3, 0, 3'd3, 0, 3'd0, 0, 10'h155, 10'h155, 8'h00);
    step(0, 1, 3'd3, 10'h0AA, 0, 3'd3, 0, 3'd5, 0, 3'd0, 0, 10'h0AA, 10'h2A5, 8'h00);
    // load to r2, read-after-load stall, then completion with bypass
    step(0, 0, 3'd0, 10'h000, 0, 3'd3, 0, 3'd3, 1, 3'd2, 0, 10'h0AA, 10'h0AA, 8'h04);
    step(0, 0, 3'd0, 10'h000, 1, 3'd2, 0, 3'd3, 0, 3'd0, 1, 10'h000, 10'h0AA, 8'h04);
    step(0, 1, 3'd2, 10'h3FF, 1, 3'd2, 0, 3'd3, 0, 3'd0, 0, 10'h3FF, 10'h0AA, 8'h00);
    // set beats clear on r4
    step(0, 0, 3'd0, 10'h000, 0, 3'd2, 0, 3'd3, 1, 3'd4, 0, 10'h3FF, 10'h0AA, 8'h10);
    step(0, 1, 3'd4, 10'h123, 0, 3'd4, 0, 3'd4, 1, 3'd4, 0, 10'h123, 10'h123, 8'h10);
    // stall from port 2 on r1 drops the new r4 load, so pending[4] clears
    step(0, 0, 3'd0, 10'h000, 0, 3'd4, 0, 3'd0, 1, 3'd1, 0, 10'h123, 10'h000, 8'h12);
    step(0, 1, 3'd4, 10'h0F0, 0, 3'd4, 1, 3'd1, 1, 3'd4, 1, 10'h0F0, 10'h000, 8'h02);
    // second load to an already pending register leaves the bit set
    step(0, 0, 3'd0, 10'h000, 0, 3'd4, 0, 3'd5, 1, 3'd1, 0, 10'h0F0, 10'h2A5, 8'h02);
    step(0, 0, 3'd0, 10'h000, 0, 3'd0, 0, 3'd7, 1, 3'd7, 0, 10'h000, 10'h000, 8'h82);
    step(0, 0, 3'd0, 10'h000, 0, 3'd6, 0, 3'd6, 1, 3'd6, 0, 10'h000, 10'h000, 8'hC2);
    // r0 is writable; reading pending r6 with rd_en2=0 does not stall
    step(0, 1, 3'd0, 10'h001, 0, 3'd0, 0, 3'd6, 0, 3'd0, 0, 10'h001, 10'h000, 8'hC2);
    // rd_en2=1 on pending r6 stalls and the r0 load is ignored
    step(0, 0, 3'd0, 10'h000, 0, 3'd0, 1, 3'd6, 1, 3'd0, 1, 10'h001, 10'h000, 8'hC2);
    // r6 completes on port 1 (no stall from it) while port 2 still waits on r1
    step(0, 1, 3'd6, 10'h2DB, 1, 3'd6, 1, 3'd1, 0, 3'd0, 1, 10'h2DB, 10'h000, 8'h82);
    // reset mid-operation with write, load and a would-be stall
    step(1, 1, 3'd5, 10'h111, 1, 3'd1, 0, 3'd0, 1, 3'd3, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 0, 3'd0, 0, 3'd1, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 0, 3'd2, 0, 3'd3, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 1, 3'd4, 1, 3'd5, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);
    step(0, 0, 3'd0, 10'h000, 1, 3'd6, 1, 3'd7, 0, 3'd0, 0, 10'h000, 10'h000, 8'h00);

    @(posedge clk);
    #1;
    reset = 1'b0; wb_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0; issue_load = 1'b0;

    for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) begin
      @(posedge clk);
      #3;
    end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations still queued, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
